id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- MIPS instruction-decode stage that sits directly upstream of register_file.
- Splits the fetched instruction into fields and drives the register file read addresses combinationally.
- Decodes control and sign/zero-extends the immediate.
- Captures operands and control into the ID/EX pipeline register.
- Detects load-use hazards (stall) and accepts a branch flush from EX.

Parameters:
- DATA_W, 32, register/data width.
- REG_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  if_instr/if_pc4 hold a real instruction
- if_instr  in  32  instruction word
- if_pc4  in  32  PC+4 of if_instr
- flush  in  1  branch taken in EX; kill the instruction in ID
- id_stall  out  1  IF must hold PC and instruction this cycle
- rf_read_reg1  out  REG_W  if_instr[25:21] (rs), combinational
- rf_read_reg2  out  REG_W  if_instr[20:16] (rt), combinational
- rf_read_data1  in  DATA_W  register file port 1 data
- rf_read_data2  in  DATA_W  register file port 2 data
- wb_write_en  in  1  writeback write enable (same signal register_file sees)
- wb_write_reg  in  REG_W  writeback destination
- wb_write_data  in  DATA_W  writeback data
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc4  out  32  registered PC+4
- ex_rs_data  out  DATA_W  registered operand A
- ex_rt_data  out  DATA_W  registered operand B
- ex_imm  out  32  extended immediate
- ex_rs  out  REG_W  registered rs index
- ex_rt  out  REG_W  registered rt index
- ex_dst  out  REG_W  destination register index
- ex_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 NOR, 6 LUI
- ex_alu_src  out  1  operand B = ex_imm
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_mem_to_reg  out  1  writeback from memory
- ex_reg_write  out  1  writeback enable
- ex_branch  out  1  beq
- ex_illegal  out  1  undecodable opcode/funct

Behaviour:
- One clock, clk.
- Reset is synchronous and active-high on rst.
- Reset values: every ex_* output is 0. id_stall is therefore 0.
- Decode by opcode:
  - 0x00 R-type, funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x27 NOR; dst = rd.
  - 0x08 addi ADD; 0x0A slti SLT; imm sign-extended.
  - 0x0C andi AND; 0x0D ori OR; imm zero-extended.
  - 0x0F lui LUI; imm = {instr[15:0], 16'h0}.
  - 0x23 lw: ADD, mem_read, mem_to_reg.
  - 0x2B sw: ADD, mem_write, no reg_write.
  - 0x04 beq: SUB, branch, alu_src = 0.
  - For every I-type except sw and beq: dst = rt and alu_src = 1. sw also uses alu_src = 1.
- Any other opcode or funct: ex_illegal = 1; all control bits 0 except ex_valid.
- ex_reg_write is forced to 0 when the destination is $0.
- Operand read:
  - Operand data is forced to 0 when its index is 0, regardless of rf_read_data.
  - Otherwise operand = rf data (bypass: see Optional Feature).
- Source use:
  - rs is used by all instructions except lui.
  - rt is used by R-type, sw and beq.
- Load-use hazard = ex_valid & ex_mem_read & ex_rt != 0 & if_valid & ((rs used & rs == ex_rt) | (rt used & rt == ex_rt)).
- Per-edge priority:
  - rst → reset values.
  - flush → bubble (ex_valid and all control 0; data fields don't-care); id_stall = 0.
  - hazard → bubble; id_stall = 1.
  - if_valid = 0 → bubble.
  - otherwise → load the decoded instruction with ex_valid = 1.
- id_stall is combinational: hazard & ~flush.
- A stall lasts exactly one cycle, because the bubble clears ex_mem_read.
- Latency: instruction present on if_* → visible on ex_* after 1 clk edge.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - If wb_write_en & wb_write_reg != 0 & wb_write_reg == rs, operand A = wb_write_data. The same rule applies to rt and operand B.
  - This covers register_file writing and being read in the same cycle.
  - The $0 rule still has priority.
- Undefined:
  - Operands come straight from rf_read_data*.
  - Software must separate a writer and a dependent reader by at least one instruction.

Test Plan:
- Reset: rst = 1 for 2 cycles with if_valid = 1, instr 0x012A4020 → all ex_* = 0; id_stall = 0.
- add $8,$9,$10 (0x012A4020), rf data 5400/3600 → next edge: ex_valid = 1, ex_rs_data = 5400, ex_rt_data = 3600, ex_dst = 8, ex_alu_op = 0, ex_reg_write = 1.
- addi $3,$0,-4 (0x2003FFFC), rf_read_data1 = 7200 → ex_rs_data = 0, ex_imm = 0xFFFFFFFC, ex_alu_src = 1. Also ori $3,$0,0x8000 → ex_imm = 0x00008000.
- lw $2,0($1), then add $4,$2,$3 → id_stall = 1 for exactly one cycle; ex_valid = 0 that cycle; add reaches ex_* on the following edge.
- Flush asserted in the same cycle as the load-use hazard → id_stall = 0; ex_valid = 0 next edge.
- WB_BYPASS_EN defined: wb_write_en = 1, wb_write_reg = 2, wb_write_data = 1800, add $4,$2,$2, rf data = 9000 → ex_rs_data = ex_rt_data = 1800. Undefined: both = 9000.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS instruction-decode stage with ID/EX pipeline register
//
// Splits if_instr into fields, drives the register-file read addresses
// combinationally, decodes control, extends the immediate and registers
// everything into ID/EX. Detects load-use hazards (id_stall) and accepts a
// branch flush from EX.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_valid, if_instr, if_pc4     fetched instruction from IF
//   flush                          kill the instruction in ID
//   id_stall                       IF must hold PC/instruction this cycle
//   rf_read_reg1/2, rf_read_data1/2  register-file read ports
//   wb_write_en/reg/data           writeback bus (bypass source)
//   ex_*                           ID/EX pipeline register outputs
//
// Optional feature: define WB_BYPASS_EN to forward same-cycle writeback data
// into the operands.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_pc4,
    input  logic              flush,
    output logic              id_stall,
    output logic [REG_W-1:0]  rf_read_reg1,
    output logic [REG_W-1:0]  rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_write_en,
    input  logic [REG_W-1:0]  wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [31:0]       ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dst,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic              ex_illegal
);
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                           ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_NOR = 3'd5,
                           ALU_LUI = 3'd6;

    logic [5:0]       opcode, funct;
    logic [REG_W-1:0] rs, rt, rd;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign funct  = if_instr[5:0];

    assign rf_read_reg1 = rs;
    assign rf_read_reg2 = rt;

    // Decoded control (before bubble insertion)
    logic [2:0]       dec_alu_op;
    logic             dec_alu_src, dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic             dec_reg_write, dec_branch, dec_illegal;
    logic [REG_W-1:0] dec_dst;
    logic [31:0]      dec_imm;
    logic             rs_used, rt_used;

    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_illegal    = 1'b0;
        dec_dst        = '0;
        dec_imm        = {{16{if_instr[15]}}, if_instr[15:0]};
        rs_used        = 1'b1;
        rt_used        = 1'b0;
        case (opcode)
            6'h00: begin
                rt_used       = 1'b1;
                dec_dst       = rd;
                dec_reg_write = 1'b1;
                case (funct)
                    6'h20: dec_alu_op = ALU_ADD;
                    6'h22: dec_alu_op = ALU_SUB;
                    6'h24: dec_alu_op = ALU_AND;
                    6'h25: dec_alu_op = ALU_OR;
                    6'h2A: dec_alu_op = ALU_SLT;
                    6'h27: dec_alu_op = ALU_NOR;
                    default: begin
                        dec_illegal   = 1'b1;
                        dec_reg_write = 1'b0;
                        dec_dst       = '0;
                    end
                endcase
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin
                dec_dst       = rt;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                case (opcode)
                    6'h0A: dec_alu_op = ALU_SLT;
                    6'h0C: begin
                        dec_alu_op = ALU_AND;
                        dec_imm    = {16'h0, if_instr[15:0]};
                    end
                    6'h0D: begin
                        dec_alu_op = ALU_OR;
                        dec_imm    = {16'h0, if_instr[15:0]};
                    end
                    6'h0F: begin
                        dec_alu_op = ALU_LUI;
                        dec_imm    = {if_instr[15:0], 16'h0};
                        rs_used    = 1'b0;
                    end
                    6'h23: begin
                        dec_mem_read   = 1'b1;
                        dec_mem_to_reg = 1'b1;
                    end
                    default: dec_alu_op = ALU_ADD;
                endcase
            end
            6'h2B: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                rt_used       = 1'b1;
            end
            6'h04: begin
                dec_alu_op = ALU_SUB;
                dec_branch = 1'b1;
                rt_used    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Operand selection; the $0 rule always wins
    logic [DATA_W-1:0] op_a, op_b;
`ifdef WB_BYPASS_EN
    logic byp_a, byp_b;
    assign byp_a = wb_write_en && (wb_write_reg != '0) && (wb_write_reg == rs);
    assign byp_b = wb_write_en && (wb_write_reg != '0) && (wb_write_reg == rt);
    assign op_a  = (rs == '0) ? '0 : (byp_a ? wb_write_data : rf_read_data1);
    assign op_b  = (rt == '0) ? '0 : (byp_b ? wb_write_data : rf_read_data2);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write_en, wb_write_reg, wb_write_data};
    assign op_a = (rs == '0) ? '0 : rf_read_data1;
    assign op_b = (rt == '0) ? '0 : rf_read_data2;
`endif

    // Load-use hazard against the load currently in EX
    logic hazard, bubble;
    assign hazard = ex_valid && ex_mem_read && (ex_rt != '0) && if_valid &&
                    ((rs_used && (rs == ex_rt)) || (rt_used && (rt == ex_rt)));
    assign id_stall = hazard && !flush;
    assign bubble   = flush || hazard || !if_valid;

    // ID/EX register: control is zeroed on a bubble, data fields load freely
    logic [9:0] ctrl_d, ctrl_q;
    logic       valid_d, valid_q;
    assign valid_d = !bubble;
    assign ctrl_d  = bubble ? 10'd0 :
                     {dec_alu_op, dec_alu_src, dec_mem_read, dec_mem_write,
                      dec_mem_to_reg, dec_reg_write && (dec_dst != '0),
                      dec_branch, dec_illegal};

    logic [31:0]       pc4_q, imm_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q;
    logic [REG_W-1:0]  rs_q, rt_q, dst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            imm_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc4_q     <= if_pc4;
            imm_q     <= dec_imm;
            rs_data_q <= op_a;
            rt_data_q <= op_b;
            rs_q      <= rs;
            rt_q      <= rt;
            dst_q     <= dec_dst;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc4     = pc4_q;
    assign ex_imm     = imm_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_dst     = dst_q;
    assign {ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
            ex_reg_write, ex_branch, ex_illegal} = ctrl_q;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst, if_valid, flush, id_stall;
    logic [31:0] if_instr, if_pc4;
    logic [4:0]  rf_read_reg1, rf_read_reg2, wb_write_reg;
    logic [31:0] rf_read_data1, rf_read_data2, wb_write_data;
    logic        wb_write_en;
    logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_reg_write, ex_branch, ex_illegal;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [2:0]  ex_alu_op;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc4(if_pc4), .flush(flush), .id_stall(id_stall),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_write_en(wb_write_en), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic        stall, valid;
        logic [9:0]  ctrl;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dst;
        logic        chk_data, chk_imm, chk_dst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // {alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, illegal}
    function automatic logic [9:0] c(input logic [2:0] op, input logic src, mr, mw,
                                     m2r, rw, br, ill);
        return {op, src, mr, mw, m2r, rw, br, ill};
    endfunction

    function automatic exp_t ins(input logic [31:0] pc4, rsd, rtd, imm, input logic ci,
                                 input logic [4:0] rs, rt, dst, input logic cd,
                                 input logic [9:0] ctrl);
        exp_t e;
        e.stall = 1'b0; e.valid = 1'b1; e.ctrl = ctrl; e.pc4 = pc4;
        e.rs_data = rsd; e.rt_data = rtd; e.imm = imm; e.rs = rs; e.rt = rt;
        e.dst = dst; e.chk_data = 1'b1; e.chk_imm = ci; e.chk_dst = cd;
        return e;
    endfunction

    function automatic exp_t bub(input logic stall);
        exp_t e;
        e = ins('0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
        e.stall = stall; e.valid = 1'b0; e.chk_data = 1'b0;
        return e;
    endfunction

    task automatic step(input logic r, v, input logic [31:0] instr, pc4, d1, d2,
                        input logic fl, input exp_t e);
        rst = r; if_valid = v; if_instr = instr; if_pc4 = pc4;
        rf_read_data1 = d1; rf_read_data2 = d2; flush = fl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: id_stall checked in the cycle the inputs are applied,
    // the ID/EX contents on the following negedge.
    initial begin
        exp_t pend;
        logic pend_v = 1'b0;
        forever begin
            @(negedge clk);
            if (pend_v) begin
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, pend.valid});
                chk("ex_ctrl", {22'd0, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
                    ex_mem_to_reg, ex_reg_write, ex_branch, ex_illegal}, {22'd0, pend.ctrl});
                if (pend.chk_data) begin
                    chk("ex_pc4", ex_pc4, pend.pc4);
                    chk("ex_rs_data", ex_rs_data, pend.rs_data);
                    chk("ex_rt_data", ex_rt_data, pend.rt_data);
                    chk("ex_rs", {27'd0, ex_rs}, {27'd0, pend.rs});
                    chk("ex_rt", {27'd0, ex_rt}, {27'd0, pend.rt});
                end
                if (pend.chk_imm) chk("ex_imm", ex_imm, pend.imm);
                if (pend.chk_dst) chk("ex_dst", {27'd0, ex_dst}, {27'd0, pend.dst});
            end
            if (exp_q.size() > 0) begin
                pend = exp_q.pop_front();
                pend_v = 1'b1;
                chk("id_stall", {31'd0, id_stall}, {31'd0, pend.stall});
            end else begin
                pend_v = 1'b0;
            end
        end
    end

    localparam logic [31:0] ADD  = 32'h012A4020, LW = 32'h8C220000, ADDU2 = 32'h00432020;
    localparam logic [31:0] BEQ  = 32'h10220003;
    logic [31:0] byp_val;
    exp_t rst_e;

    initial begin
`ifdef WB_BYPASS_EN
        byp_val = 32'd1800;
`else
        byp_val = 32'd9000;
`endif
        wb_write_en = 1'b0; wb_write_reg = '0; wb_write_data = '0;
        rst = 1'b1; if_valid = 1'b1; if_instr = ADD; if_pc4 = 32'h100;
        rf_read_data1 = 32'd1; rf_read_data2 = 32'd2; flush = 1'b0;
        @(posedge clk);
        #1;
        rst_e = ins('0, '0, '0, '0, 1'b1, '0, '0, '0, 1'b1, '0);
        rst_e.valid = 1'b0;
        step(1, 1, ADD, 32'h100, 1, 2, 0, rst_e);
        // decode coverage
        step(0, 1, ADD, 32'h104, 5400, 3600, 0,
             ins(32'h104, 5400, 3600, 0, 0, 9, 10, 8, 1, c(0,0,0,0,0,1,0,0)));
        step(0, 1, 32'h2003FFFC, 32'h108, 7200, 11, 0,
             ins(32'h108, 0, 11, 32'hFFFFFFFC, 1, 0, 3, 3, 1, c(0,1,0,0,0,1,0,0)));
        step(0, 1, 32'h34038000, 32'h10C, 7200, 22, 0,
             ins(32'h10C, 0, 22, 32'h00008000, 1, 0, 3, 3, 1, c(3,1,0,0,0,1,0,0)));
        step(0, 1, 32'h28C5FFFF, 32'h110, 100, 200, 0,
             ins(32'h110, 100, 200, 32'hFFFFFFFF, 1, 6, 5, 5, 1, c(4,1,0,0,0,1,0,0)));
        step(0, 1, 32'h3C071234, 32'h114, 1, 2, 0,
             ins(32'h114, 0, 2, 32'h12340000, 1, 0, 7, 7, 1, c(6,1,0,0,0,1,0,0)));
        step(0, 1, 32'hACC50008, 32'h118, 30, 40, 0,
             ins(32'h118, 30, 40, 32'h8, 1, 6, 5, 0, 0, c(0,1,0,1,0,0,0,0)));
        step(0, 1, BEQ, 32'h11C, 50, 60, 0,
             ins(32'h11C, 50, 60, 32'h3, 1, 1, 2, 0, 0, c(1,0,0,0,0,0,1,0)));
        step(0, 1, 32'hFC000000, 32'h120, 3, 4, 0,
             ins(32'h120, 0, 0, 0, 0, 0, 0, 0, 0, c(0,0,0,0,0,0,0,1)));
        step(0, 1, 32'h012A4021, 32'h124, 1, 2, 0,
             ins(32'h124, 1, 2, 0, 0, 9, 10, 0, 0, c(0,0,0,0,0,0,0,1)));
        step(0, 1, 32'h012A0020, 32'h128, 7, 8, 0,
             ins(32'h128, 7, 8, 0, 0, 9, 10, 0, 1, c(0,0,0,0,0,0,0,0)));
        step(0, 0, ADD, 32'h12C, 7, 8, 0, bub(0));
        // load-use via rs: one stall cycle, then the add issues
        step(0, 1, LW, 32'h130, 1000, 77, 0,
             ins(32'h130, 1000, 77, 0, 1, 1, 2, 2, 1, c(0,1,1,0,1,1,0,0)));
        step(0, 1, ADDU2, 32'h134, 5, 6, 0, bub(1));
        step(0, 1, ADDU2, 32'h134, 5, 6, 0,
             ins(32'h134, 5, 6, 0, 0, 2, 3, 4, 1, c(0,0,0,0,0,1,0,0)));
        // flush coinciding with the hazard
        step(0, 1, LW, 32'h138, 1000, 77, 0,
             ins(32'h138, 1000, 77, 0, 1, 1, 2, 2, 1, c(0,1,1,0,1,1,0,0)));
        step(0, 1, ADDU2, 32'h13C, 5, 6, 1, bub(0));
        step(0, 1, ADDU2, 32'h140, 5, 6, 0,
             ins(32'h140, 5, 6, 0, 0, 2, 3, 4, 1, c(0,0,0,0,0,1,0,0)));
        // load-use via rt (beq)
        step(0, 1, LW, 32'h144, 1000, 77, 0,
             ins(32'h144, 1000, 77, 0, 1, 1, 2, 2, 1, c(0,1,1,0,1,1,0,0)));
        step(0, 1, BEQ, 32'h148, 50, 60, 0, bub(1));
        step(0, 1, BEQ, 32'h148, 50, 60, 0,
             ins(32'h148, 50, 60, 32'h3, 1, 1, 2, 0, 0, c(1,0,0,0,0,0,1,0)));
        // addi's rt is a destination, not a source: no stall
        step(0, 1, LW, 32'h14C, 1000, 77, 0,
             ins(32'h14C, 1000, 77, 0, 1, 1, 2, 2, 1, c(0,1,1,0,1,1,0,0)));
        step(0, 1, 32'h20620001, 32'h150, 33, 44, 0,
             ins(32'h150, 33, 44, 32'h1, 1, 3, 2, 2, 1, c(0,1,0,0,0,1,0,0)));
        // writeback bypass (or not) on add $4,$2,$2
        wb_write_en = 1'b1; wb_write_reg = 5'd2; wb_write_data = 32'd1800;
        step(0, 1, 32'h00422020, 32'h154, 9000, 9000, 0,
             ins(32'h154, byp_val, byp_val, 0, 0, 2, 2, 4, 1, c(0,0,0,0,0,1,0,0)));
        wb_write_en = 1'b0; wb_write_reg = '0; wb_write_data = '0;
        // hazard requires if_valid; plain flush gives a bubble
        step(0, 1, LW, 32'h158, 1000, 77, 0,
             ins(32'h158, 1000, 77, 0, 1, 1, 2, 2, 1, c(0,1,1,0,1,1,0,0)));
        step(0, 0, ADDU2, 32'h15C, 5, 6, 0, bub(0));
        step(0, 1, ADD, 32'h160, 5400, 3600, 1, bub(0));
        step(0, 1, ADD, 32'h164, 5400, 3600, 0,
             ins(32'h164, 5400, 3600, 0, 0, 9, 10, 8, 1, c(0,0,0,0,0,1,0,0)));
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
